alu_riscv: RTL and testbench

- Execute-stage datapath slice of the multicycle RISC-V core.
- Comprises the immediate extender, the 2:1 32-bit operand-B select, the 3-bit-controlled ALU with NZCV flags, and the ALUOut pipeline register.
- Sits between the register-file read buffers and the result mux.
- The control unit consumes the flags combinationally in the same cycle.

---
 rtl/alu_riscv_pkg.sv | 25 ++
 rtl/alu_riscv_imm_extender.sv | 30 +++
 rtl/alu_riscv.sv | 101 ++++++++++
 tb/tb_alu_riscv.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_riscv_pkg
// Description : ALU operation codes and immediate-format selects shared by
//               the execute-stage slice.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage : alu_riscv_pkg
`default_nettype wire

// File: rtl/alu_riscv_imm_extender.sv
`default_nettype none
// ============================================================================
// Module      : imm_extender
// Description : Combinational sign-extender for I/S/B/J immediates.
//               instr_ext carries Instr[31:7], so Instr[k] = instr_ext[k-7].
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extender
    import alu_riscv_pkg::*;
(
    input  logic [24:0] instr_ext,
    input  logic [1:0]  imm_src,
    output logic [31:0] imm_ext
);

    always_comb begin
        imm_ext = 32'd0;
        case (imm_src)
            IMM_I: imm_ext = {{20{instr_ext[24]}}, instr_ext[24:13]};
            IMM_S: imm_ext = {{20{instr_ext[24]}}, instr_ext[24:18], instr_ext[4:0]};
            IMM_B: imm_ext = {{19{instr_ext[24]}}, instr_ext[24], instr_ext[0],
                              instr_ext[23:18], instr_ext[4:1], 1'b0};
            IMM_J: imm_ext = {{11{instr_ext[24]}}, instr_ext[24], instr_ext[12:5],
                              instr_ext[13], instr_ext[23:14], 1'b0};
            default: imm_ext = 32'd0;
        endcase
    end

endmodule : imm_extender
`default_nettype wire

// File: rtl/alu_riscv.sv
`default_nettype none
// ============================================================================
// Module      : alu_riscv
// Description : Execute-stage slice: immediate extender, operand-B select,
//               NZCV ALU and the ALUOut register. Shifts are built only when
//               ALU_RISCV_SHIFT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_riscv
    import alu_riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [24:0]     instr_ext,
    input  logic [1:0]      imm_src,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            b_sel,
    input  logic [2:0]      alu_ctrl,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    output logic            negative,
    output logic            carry,
    output logic            overflow
);

    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_b;
    logic            w_sub;
    logic [XLEN-1:0] w_b_add;
    logic [XLEN:0]   w_sum;
    logic            w_sum_v;
    logic            w_less;
    logic [XLEN-1:0] w_result;
    logic            w_carry;
    logic            w_overflow;
    logic [XLEN-1:0] r_alu_out;

    imm_extender u_imm_extender (
        .instr_ext (instr_ext),
        .imm_src   (imm_src),
        .imm_ext   (w_imm)
    );

    assign w_b = b_sel ? w_imm : rs2_val;

    // SLT shares the subtractor, so both SUB and SLT invert B and add one.
    assign w_sub   = (alu_ctrl == ALU_SUB) || (alu_ctrl == ALU_SLT);
    assign w_b_add = w_sub ? ~w_b : w_b;
    assign w_sum   = {1'b0, src_a} + {1'b0, w_b_add} + {{XLEN{1'b0}}, w_sub};
    assign w_sum_v = (src_a[XLEN-1] == w_b_add[XLEN-1]) &&
                     (w_sum[XLEN-1] != src_a[XLEN-1]);
    assign w_less  = w_sum[XLEN-1] ^ w_sum_v;

    always_comb begin
        w_result   = {XLEN{1'b0}};
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (alu_ctrl)
            ALU_ADD, ALU_SUB: begin
                w_result   = w_sum[XLEN-1:0];
                w_carry    = w_sum[XLEN];
                w_overflow = w_sum_v;
            end
            ALU_AND: w_result = src_a & w_b;
            ALU_OR:  w_result = src_a | w_b;
            ALU_XOR: w_result = src_a ^ w_b;
            ALU_SLT: w_result = {{(XLEN-1){1'b0}}, w_less};
`ifdef ALU_RISCV_SHIFT_EN
            ALU_SLL: w_result = src_a << w_b[4:0];
            ALU_SRL: w_result = src_a >> w_b[4:0];
`else
            ALU_SLL: w_result = {XLEN{1'b0}};
            ALU_SRL: w_result = {XLEN{1'b0}};
`endif
            default: w_result = {XLEN{1'b0}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_out <= {XLEN{1'b0}};
        end else begin
            r_alu_out <= w_result;
        end
    end

    assign imm_ext    = w_imm;
    assign alu_result = w_result;
    assign alu_out    = r_alu_out;
    assign zero       = (w_result == {XLEN{1'b0}});
    assign negative   = w_result[XLEN-1];
    assign carry      = w_carry;
    assign overflow   = w_overflow;

endmodule : alu_riscv
`default_nettype wire

// File: tb/tb_alu_riscv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_riscv
// Description : Directed-vector scoreboard bench for alu_riscv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_riscv;

    logic        clk;
    logic        reset;
    logic [24:0] instr_ext;
    logic [1:0]  imm_src;
    logic [31:0] src_a;
    logic [31:0] rs2_val;
    logic        b_sel;
    logic [2:0]  alu_ctrl;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic        zero, negative, carry, overflow;

    typedef struct {
        string       name;
        logic [31:0] imm;
        logic [31:0] res;
        logic [3:0]  zncv;
        logic [31:0] out;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] prev_res;
    logic        prev_rst;

    alu_riscv #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_ext  (instr_ext),
        .imm_src    (imm_src),
        .src_a      (src_a),
        .rs2_val    (rs2_val),
        .b_sel      (b_sel),
        .alu_ctrl   (alu_ctrl),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .alu_out    (alu_out),
        .zero       (zero),
        .negative   (negative),
        .carry      (carry),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected alu_out reflects the vector presented before the last edge.
    task automatic apply(input string nm, input logic rst, input logic [24:0] ie,
                         input logic [1:0] is, input logic [31:0] a, input logic [31:0] b,
                         input logic bs, input logic [2:0] op, input logic [31:0] e_imm,
                         input logic [31:0] e_res, input logic [3:0] e_zncv);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; instr_ext = ie; imm_src = is; src_a = a; rs2_val = b;
        b_sel = bs; alu_ctrl = op;
        e.name = nm; e.imm = e_imm; e.res = e_res; e.zncv = e_zncv;
        e.out  = prev_rst ? 32'd0 : prev_res;
        sb_q.push_back(e);
        prev_res = e_res;
        prev_rst = rst;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.name, ".imm"},    imm_ext, e.imm);
                chk({e.name, ".result"}, alu_result, e.res);
                chk({e.name, ".zncv"},   {28'd0, zero, negative, carry, overflow},
                                         {28'd0, e.zncv});
                chk({e.name, ".alu_out"}, alu_out, e.out);
            end
        end
    end

`ifdef ALU_RISCV_SHIFT_EN
    localparam logic [31:0] SLL35_R = 32'd8;        localparam logic [3:0] SLL35_F = 4'b0000;
    localparam logic [31:0] SRL31_R = 32'd1;        localparam logic [3:0] SRL31_F = 4'b0000;
    localparam logic [31:0] SLL4_R  = 32'hFFFFFFF0; localparam logic [3:0] SLL4_F  = 4'b0100;
`else
    localparam logic [31:0] SLL35_R = 32'd0;        localparam logic [3:0] SLL35_F = 4'b1000;
    localparam logic [31:0] SRL31_R = 32'd0;        localparam logic [3:0] SRL31_F = 4'b1000;
    localparam logic [31:0] SLL4_R  = 32'd0;        localparam logic [3:0] SLL4_F  = 4'b1000;
`endif

    initial begin : stimulus
        bit drained;
        reset = 1'b1; instr_ext = '0; imm_src = 2'b00; src_a = '0; rs2_val = '0;
        b_sel = 1'b0; alu_ctrl = 3'b000;
        prev_res = '0; prev_rst = 1'b1;
        repeat (2) @(posedge clk);

        //     name        rst ie            is     a             b             bs   op      imm           res           ZNCV
        apply("reset",     1, 25'h0,        2'b00, 32'h0,        32'h0,        0, 3'b000, 32'h0,        32'h0,        4'b1000);
        apply("add_ovf",   0, 25'h0,        2'b00, 32'h7FFFFFFF, 32'h1,        0, 3'b000, 32'h0,        32'h80000000, 4'b0101);
        apply("sub_eq",    0, 25'h0,        2'b00, 32'd5,        32'd5,        0, 3'b001, 32'h0,        32'h0,        4'b1010);
        apply("sub_brw",   0, 25'h0,        2'b00, 32'd3,        32'd5,        0, 3'b001, 32'h0,        32'hFFFFFFFE, 4'b0100);
        apply("sub_ovf",   0, 25'h0,        2'b00, 32'h80000000, 32'h1,        0, 3'b001, 32'h0,        32'h7FFFFFFF, 4'b0011);
        apply("add_wrap",  0, 25'h0,        2'b00, 32'hFFFFFFFF, 32'h1,        0, 3'b000, 32'h0,        32'h0,        4'b1010);
        apply("and",       0, 25'h0,        2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 0, 3'b010, 32'h0,        32'hF000F000, 4'b0100);
        apply("or",        0, 25'h0,        2'b00, 32'h0F0F0000, 32'h000000F0, 0, 3'b011, 32'h0,        32'h0F0F00F0, 4'b0000);
        apply("xor",       0, 25'h0,        2'b00, 32'hAAAAAAAA, 32'hAAAAAAAA, 0, 3'b100, 32'h0,        32'h0,        4'b1000);
        apply("slt_m1_1",  0, 25'h0,        2'b00, 32'hFFFFFFFF, 32'h1,        0, 3'b101, 32'h0,        32'h1,        4'b0000);
        apply("slt_1_m1",  0, 25'h0,        2'b00, 32'h1,        32'hFFFFFFFF, 0, 3'b101, 32'h0,        32'h0,        4'b1000);
        apply("slt_vflow", 0, 25'h0,        2'b00, 32'h80000000, 32'h7FFFFFFF, 0, 3'b101, 32'h0,        32'h1,        4'b0000);
        apply("imm_i",     0, 25'h1FFE000,  2'b00, 32'h0,        32'h0,        1, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0100);
        apply("imm_s",     0, 25'h1FC0018,  2'b01, 32'h8,        32'h0,        1, 3'b000, 32'hFFFFFFF8, 32'h0,        4'b1010);
        apply("imm_b",     0, 25'h1FC001D,  2'b10, 32'h0,        32'h0,        1, 3'b000, 32'hFFFFFFFC, 32'hFFFFFFFC, 4'b0100);
        apply("imm_j",     0, 25'h0002000,  2'b11, 32'h0,        32'h0,        1, 3'b000, 32'h00000800, 32'h00000800, 4'b0000);
        apply("pre_rst",   0, 25'h0,        2'b00, 32'h1234,     32'h0,        0, 3'b000, 32'h0,        32'h1234,     4'b0000);
        apply("mid_rst",   1, 25'h0,        2'b00, 32'h1,        32'h1,        0, 3'b000, 32'h0,        32'h2,        4'b0000);
        apply("post_rst",  0, 25'h0,        2'b00, 32'h1,        32'h1,        0, 3'b000, 32'h0,        32'h2,        4'b0000);
        apply("sll35",     0, 25'h0,        2'b00, 32'h1,        32'd35,       0, 3'b110, 32'h0,        SLL35_R,      SLL35_F);
        apply("srl31",     0, 25'h0,        2'b00, 32'h80000000, 32'd31,       0, 3'b111, 32'h0,        SRL31_R,      SRL31_F);
        apply("sll4",      0, 25'h0,        2'b00, 32'hFFFFFFFF, 32'd4,        0, 3'b110, 32'h0,        SLL4_R,       SLL4_F);
        apply("flush",     0, 25'h0,        2'b00, 32'h0,        32'h0,        0, 3'b000, 32'h0,        32'h0,        4'b1000);

        drained = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_riscv
`default_nettype wire
